// File: rtl/bus_arbiter_pkg.sv
// Shared types and default address map for the imem/dmem bus arbiter.
package bus_arbiter_pkg;
  typedef enum logic [2:0] {ROM, PRINT, CLINT, RAM, NONE} region_t;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  typedef enum logic {IMEM, DMEM} master_t;

  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0000_0080;
  localparam logic [31:0] PRINT_BASE = 32'h0100_0000;
  localparam logic [31:0] PRINT_TOP  = 32'h0100_0004;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
  localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
  localparam logic [31:0] RAM_TOP    = 32'h9000_0000;

  // One-hot select ordered {ram,clint,print,rom}; NONE selects nothing.
  function automatic logic [3:0] region_sel(region_t r);
    case (r)
      ROM:     return 4'b0001;
      PRINT:   return 4'b0010;
      CLINT:   return 4'b0100;
      RAM:     return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/bus_decoder.sv
// Combinational address decode into a hit flag and one-hot slave select.
module bus_decoder
  import bus_arbiter_pkg::*;
#(
  parameter logic [31:0] rom_base   = ROM_BASE,
  parameter logic [31:0] rom_top    = ROM_TOP,
  parameter logic [31:0] print_base = PRINT_BASE,
  parameter logic [31:0] print_top  = PRINT_TOP,
  parameter logic [31:0] clint_base = CLINT_BASE,
  parameter logic [31:0] clint_top  = CLINT_TOP,
  parameter logic [31:0] ram_base   = RAM_BASE,
  parameter logic [31:0] ram_top    = RAM_TOP
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [3:0]  sel
);
  region_t region;

  always_comb begin
    region = NONE;
    if (addr >= rom_base && addr < rom_top)          region = ROM;
    else if (addr >= print_base && addr < print_top) region = PRINT;
    else if (addr >= clint_base && addr < clint_top) region = CLINT;
    else if (addr >= ram_base && addr < ram_top)     region = RAM;
    hit = (region != NONE);
    sel = region_sel(region);
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between imem and dmem,
// with address decode, unmapped-address faults and a slave watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [31:0] rom_base       = ROM_BASE,
  parameter logic [31:0] rom_top        = ROM_TOP,
  parameter logic [31:0] print_base     = PRINT_BASE,
  parameter logic [31:0] print_top      = PRINT_TOP,
  parameter logic [31:0] clint_base     = CLINT_BASE,
  parameter logic [31:0] clint_top      = CLINT_TOP,
  parameter logic [31:0] ram_base       = RAM_BASE,
  parameter logic [31:0] ram_top        = RAM_TOP,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);
  localparam int WD_W = $clog2(timeout_cycles);

  state_t          state, state_nx;
  master_t         last_grant, cand;
  logic [WD_W-1:0] wd;
  logic [31:0]     mux_addr;
  logic [3:0]      sel_dec, sel_q;
  logic            hit, req_any, wd_last, done_ok, err_cyc;

  // Tie goes to whoever did not win last time.
  always_comb begin
    if (imem_valid && dmem_valid) cand = (last_grant == IMEM) ? DMEM : IMEM;
    else if (imem_valid)          cand = IMEM;
    else                          cand = DMEM;
  end

  assign req_any  = imem_valid | dmem_valid;
  assign mux_addr = (cand == IMEM) ? imem_addr : dmem_addr;
  assign wd_last  = (wd == WD_W'(timeout_cycles - 1));

  bus_decoder #(
    .rom_base(rom_base), .rom_top(rom_top),
    .print_base(print_base), .print_top(print_top),
    .clint_base(clint_base), .clint_top(clint_top),
    .ram_base(ram_base), .ram_top(ram_top)
  ) u_dec (
    .addr(mux_addr),
    .hit (hit),
    .sel (sel_dec)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = hit ? BUSY : ERR;
      BUSY:    if (bus_ready) state_nx = IDLE;
               else if (wd_last) state_nx = ERR;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slave response is forwarded combinationally in the completing cycle.
  always_comb begin
    done_ok    = (state == BUSY) && bus_ready;
    err_cyc    = (state == ERR);
    bus_valid  = (state == BUSY);
    bus_sel    = bus_valid ? sel_q : 4'b0000;
    imem_ready = (done_ok || err_cyc) && (last_grant == IMEM);
    dmem_ready = (done_ok || err_cyc) && (last_grant == DMEM);
    imem_error = err_cyc && (last_grant == IMEM);
    dmem_error = err_cyc && (last_grant == DMEM);
    imem_rdata = (done_ok && last_grant == IMEM) ? bus_rdata : 32'h0;
    dmem_rdata = (done_ok && last_grant == DMEM) ? bus_rdata : 32'h0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= DMEM;
      bus_instr  <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      bus_wstrb  <= 4'h0;
      sel_q      <= 4'h0;
      wd         <= '0;
    end else if (state == IDLE && req_any) begin
      last_grant <= cand;
      bus_instr  <= (cand == IMEM);
      bus_addr   <= mux_addr;
      bus_wdata  <= (cand == DMEM) ? dmem_wdata : 32'h0;
      bus_wstrb  <= (cand == DMEM) ? dmem_wstrb : 4'h0;
      sel_q      <= sel_dec;
      wd         <= '0;
    end else if (state == BUSY) begin
      wd <= wd + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: slave model, arbitration order, decode, faults.
module tb_bus_arbiter;
  logic        clock, reset;
  logic        imem_valid, imem_ready, imem_error;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready, dmem_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        bus_valid, bus_instr, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb, bus_sel;

  bus_arbiter dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .bus_valid(bus_valid), .bus_instr(bus_instr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_sel(bus_sel),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          instr;
    logic [3:0]  sel;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   slave_delay = 1, run = 0, last_run = 0;
  bit   slave_hang = 0, bv_seen = 0, bv_prev = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'hA5A5_A5A5);
  endfunction

  function automatic exp_t mk(input bit i, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [3:0] s, input bit e);
    exp_t r;
    r.instr = i;  r.addr = a;  r.sel = s;  r.err = e;
    r.wdata = i ? 32'h0 : wd;
    r.wstrb = i ? 4'h0 : ws;
    r.rdata = e ? 32'h0 : slave_data(a);
    return r;
  endfunction

  // Slave: answers slave_delay cycles into bus_valid, one-cycle ready pulse.
  initial begin
    int cnt;
    cnt = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (bus_ready) begin
        bus_ready = 1'b0; bus_rdata = 32'h0; cnt = 0;
      end else if (bus_valid && !slave_hang) begin
        cnt++;
        if (cnt >= slave_delay) begin
          bus_ready = 1'b1;
          bus_rdata = slave_data(bus_addr);
        end
      end else if (!bus_valid) cnt = 0;
    end
  end

  // Monitor: payload check on bus_valid rise, response check on any ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_valid) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (bus_valid && !bv_prev) begin
        bv_seen = 1;
        if (q.size() > 0)
          chk("payload", {bus_instr, bus_sel, bus_wstrb, bus_addr, bus_wdata},
              {q[0].instr, q[0].sel, q[0].wstrb, q[0].addr, q[0].wdata});
        else chk("payload_unexpected", 1, 0);
      end
      bv_prev = bus_valid;
      if (imem_ready || dmem_ready) begin
        if (q.size() == 0) chk("spurious_ready", {imem_ready, dmem_ready}, 0);
        else begin
          e = q.pop_front();
          chk("resp", {imem_ready, imem_error, imem_rdata, dmem_ready, dmem_error, dmem_rdata},
              e.instr ? {1'b1, e.err, e.rdata, 1'b0, 1'b0, 32'h0}
                      : {1'b0, 1'b0, 32'h0, 1'b1, e.err, e.rdata});
        end
      end
    end
  end

  task automatic issue(input bit is_i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit hold, output int n);
    if (is_i) begin imem_valid = 1; imem_addr = a; end
    else begin dmem_valid = 1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws; end
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if ((is_i ? imem_ready : dmem_ready) === 1'b1) begin n = k; break; end
    end
    if (n == 0) chk(is_i ? "imem_no_ready" : "dmem_no_ready", 0, 1);
    @(posedge clock); #1;
    if (!hold) begin
      if (is_i) imem_valid = 0; else dmem_valid = 0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bus"}, {bus_valid, bus_instr, bus_addr, bus_wdata, bus_wstrb, bus_sel}, 0);
    chk({tag, "_mst"}, {imem_ready, imem_error, imem_rdata, dmem_ready, dmem_error, dmem_rdata}, 0);
  endtask

  initial begin
    int n, n1, n2;
    bit          ti[8];
    logic [31:0] ta[8];
    logic [3:0]  ts[8];
    bit          te[8];
    logic [31:0] wd;
    ti = '{1, 1, 0, 0, 0, 0, 0, 0};
    ta = '{32'h7C, 32'h80, 32'h0100_0000, 32'h0100_0004,
           32'h0200_BFFC, 32'h8FFF_FFFC, 32'h9000_0000, 32'h7FFF_FFFC};
    ts = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    te = '{0, 1, 0, 1, 0, 0, 1, 1};

    reset = 0; imem_valid = 0; imem_addr = 0;
    dmem_valid = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    #2 chk_quiet("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1;

    bv_seen = 0;
    repeat (10) begin @(negedge clock); chk_quiet("idle"); end
    chk("idle_no_bus_valid", bv_seen, 0);

    // Single fetch from rom, slave answers two cycles in.
    slave_delay = 2;
    dmem_wdata = 32'h1234_5678;
    q.push_back(mk(1, 32'h0, 0, 0, 4'b0001, 0));
    issue(1, 32'h0, 0, 0, 0, n);

    // Unmapped load faults without touching the bus.
    bv_seen = 0;
    q.push_back(mk(0, 32'h0000_1000, 0, 0, 4'b0000, 1));
    issue(0, 32'h0000_1000, 32'h0, 4'h0, 0, n);
    chk("unmapped_latency", n, 2);
    chk("unmapped_no_bus_valid", bv_seen, 0);

    // Both held continuously: grants alternate I, D, I, D.
    slave_delay = 1;
    q.push_back(mk(1, 32'h4,         0, 0, 4'b0001, 0));
    q.push_back(mk(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'b1000, 0));
    q.push_back(mk(1, 32'h0100_0000, 0, 0, 4'b0010, 0));
    q.push_back(mk(0, 32'h0200_0008, 32'h0, 4'h0, 4'b0100, 0));
    fork
      begin
        issue(1, 32'h4, 0, 0, 1, n1);
        issue(1, 32'h0100_0000, 0, 0, 0, n1);
      end
      begin
        issue(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, n2);
        issue(0, 32'h0200_0008, 32'h0, 4'h0, 0, n2);
      end
    join
    chk("alternate_drained", q.size(), 0);

    // Region boundaries, both sides of base and top.
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      q.push_back(mk(ti[i], ta[i], wd, 4'h3, ts[i], te[i]));
      issue(ti[i], ta[i], wd, 4'h3, 0, n);
    end

    // Hung clint: bus_valid for exactly timeout_cycles, then an error.
    slave_hang = 1;
    q.push_back(mk(0, 32'h0200_0000, 32'h0, 4'h0, 4'b0100, 1));
    issue(0, 32'h0200_0000, 32'h0, 4'h0, 0, n);
    chk("watchdog_len", last_run, 64);

    // Reset during BUSY: bus_valid drops at once, no response follows.
    q.push_back(mk(1, 32'h8000_0000, 0, 0, 4'b1000, 0));
    imem_valid = 1; imem_addr = 32'h8000_0000;
    n = 0;
    for (int k = 0; k < 20 && !bus_valid; k++) @(negedge clock);
    chk("rst_busy_reached", bus_valid, 1);
    repeat (3) @(posedge clock);
    #3 reset = 0;
    #1 chk("rst_async_drop", bus_valid, 0);
    imem_valid = 0;
    q.delete();
    repeat (2) begin @(negedge clock); chk_quiet("in_reset"); end
    @(posedge clock); #1 reset = 1;
    slave_hang = 0;
    repeat (2) begin @(negedge clock); chk("post_rst_no_ready", {imem_ready, dmem_ready}, 0); end

    // First tie after reset goes to imem.
    q.push_back(mk(1, 32'h40, 0, 0, 4'b0001, 0));
    q.push_back(mk(0, 32'h8000_0020, 32'h0, 4'h0, 4'b1000, 0));
    fork
      issue(1, 32'h40, 0, 0, 0, n1);
      issue(0, 32'h8000_0020, 32'h0, 4'h0, 0, n2);
    join
    chk("post_rst_drained", q.size(), 0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end
endmodule
